sqgen: RTL and testbench

Test-signal generator that produces the 32-bit parallel sample words consumed by the pulse-measurement path: each `pclk` cycle it emits 32 consecutive 1-bit samples of a programmable rectangular wave (period and high time in sample units). It drives the `dsq0` input of the measurement block from on-chip, giving a closed-loop self-test of the frequency, duty, t0 and t1 readouts without an external signal source.

---
 rtl/sqgen_if.sv | 14 +
 rtl/sqgen.sv | 71 +++++++
 tb/tb_sqgen.sv | 119 +++++++++++
 3 files changed

// File: rtl/sqgen_if.sv
// sqgen_if: control inputs and sample-word outputs of the square-wave generator.
interface sqgen_if;
  logic        en;
  logic        cfg_we;
  logic [31:0] cfg_period;
  logic [31:0] cfg_high;
  logic [31:0] dsq;
  logic        sof;
  logic        run;
  logic [31:0] wcnt;
  logic        cfg_err;
  modport master (output en, cfg_we, cfg_period, cfg_high, input dsq, sof, run, wcnt, cfg_err);
  modport slave  (input en, cfg_we, cfg_period, cfg_high, output dsq, sof, run, wcnt, cfg_err);
endinterface

// File: rtl/sqgen.sv
// sqgen: emits 32 consecutive samples of a programmable rectangular wave per pclk cycle.
module sqgen #(
  parameter logic [31:0] PERIOD0  = 32'd32,
  parameter logic [31:0] HIGH0    = 32'd16,
  parameter logic        IDLE_LVL = 1'b0
) (
  input logic   pclk,
  input logic   rst,
  sqgen_if.slave s
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state_q, state_d;
  logic [31:0] per_q, per_d, hi_q, hi_d, pos_q, pos_d;
  logic [31:0] wcnt_q, wcnt_d, dsq_q, dsq_d;
  logic        sof_q, sof_d, run_q, run_d, err_q, err_d;
  logic [31:0] ph [33];
  logic [31:0] word;
  logic        hit;
  logic        cfg_ok;
  // Increment-and-wrap phase chain; pos stays below per, so p+1 never overflows.
  always_comb begin
    ph[0] = pos_q;
    word  = '0;
    hit   = 1'b0;
    for (int i = 0; i < 32; i++) begin
      word[i]  = ph[i] < hi_q;
      hit      = hit | (ph[i] == '0);
      ph[i+1]  = (ph[i] + 32'd1 == per_q) ? '0 : ph[i] + 32'd1;
    end
  end
  always_comb begin
    cfg_ok  = s.cfg_we && s.cfg_period != '0;
    state_d = s.en ? RUN : IDLE;
    per_d   = cfg_ok ? s.cfg_period : per_q;
    hi_d    = cfg_ok ? s.cfg_high : hi_q;
    pos_d   = (cfg_ok || !s.en || state_q == IDLE) ? '0 : ph[32];
    dsq_d   = (state_q == RUN) ? word : {32{IDLE_LVL}};
    sof_d   = state_q == RUN && hit;
    run_d   = state_q == RUN;
    wcnt_d  = (state_q == RUN) ? wcnt_q + 32'd1 : '0;
    err_d   = err_q | (s.cfg_we && s.cfg_period == '0);
  end
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= IDLE;
      per_q   <= PERIOD0;
      hi_q    <= HIGH0;
      pos_q   <= '0;
      wcnt_q  <= '0;
      dsq_q   <= {32{IDLE_LVL}};
      sof_q   <= 1'b0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      hi_q    <= hi_d;
      pos_q   <= pos_d;
      wcnt_q  <= wcnt_d;
      dsq_q   <= dsq_d;
      sof_q   <= sof_d;
      run_q   <= run_d;
      err_q   <= err_d;
    end
  end
  assign s.dsq     = dsq_q;
  assign s.sof     = sof_q;
  assign s.run     = run_q;
  assign s.wcnt    = wcnt_q;
  assign s.cfg_err = err_q;
endmodule

// File: tb/tb_sqgen.sv
// tb_sqgen: directed vectors for sqgen with hand-computed sample words.
module tb_sqgen;
  logic pclk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  sqgen_if bus ();
  sqgen #(.IDLE_LVL(1'b1)) dut (.pclk(pclk), .rst(rst), .s(bus));
  always #5 pclk = ~pclk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask
  task automatic cfg(input logic [31:0] p, input logic [31:0] h);
    bus.cfg_we = 1'b1;
    bus.cfg_period = p;
    bus.cfg_high = h;
    cyc();
    bus.cfg_we = 1'b0;
  endtask
  task automatic word(input string tag, input logic [31:0] d, input logic sof);
    cyc();
    chk({tag, "_dsq"}, bus.dsq, d);
    chk({tag, "_sof"}, {31'd0, bus.sof}, {31'd0, sof});
  endtask
  logic [31:0] w40 [6] = '{32'h000FFFFF, 32'h0FFFFF00, 32'hFFFF0000, 32'hFF00000F, 32'h00000FFF, 32'h000FFFFF};
  logic        s40 [6] = '{1, 1, 1, 1, 0, 1};
  logic [31:0] w100 [6] = '{32'hFFFFFFFF, 32'h0003FFFF, 32'h00000000, 32'hFFFFFFF0, 32'h003FFFFF, 32'h00000000};
  logic        s100 [6] = '{1, 0, 0, 1, 0, 0};
  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.cfg_we = 1'b0;
    bus.cfg_period = '0;
    bus.cfg_high = '0;
    cyc();
    cyc();
    chk("rst_dsq", bus.dsq, 32'hFFFFFFFF);
    chk("rst_sof", {31'd0, bus.sof}, 32'd0);
    chk("rst_run", {31'd0, bus.run}, 32'd0);
    chk("rst_wcnt", bus.wcnt, 32'd0);
    chk("rst_err", {31'd0, bus.cfg_err}, 32'd0);
    rst = 1'b0;
    bus.en = 1'b1;
    cyc();
    chk("start_run_lat", {31'd0, bus.run}, 32'd0);
    chk("start_dsq_lat", bus.dsq, 32'hFFFFFFFF);
    for (int i = 1; i <= 3; i++) begin
      word("def", 32'h0000FFFF, 1'b1);
      chk("def_wcnt", bus.wcnt, i);
      chk("def_run", {31'd0, bus.run}, 32'd1);
    end
    cfg(32'd8, 32'd3);
    chk("cfg_oldword", bus.dsq, 32'h0000FFFF);
    chk("cfg_wcnt", bus.wcnt, 32'd4);
    word("p8h3a", 32'h07070707, 1'b1);
    chk("p8_wcnt", bus.wcnt, 32'd5);
    word("p8h3b", 32'h07070707, 1'b1);
    cfg(32'd40, 32'd20);
    chk("cfg40_oldword", bus.dsq, 32'h07070707);
    for (int i = 0; i < 6; i++) word("p40h20", w40[i], s40[i]);
    cfg(32'd1, 32'd1);
    word("p1h1", 32'hFFFFFFFF, 1'b1);
    cfg(32'd5, 32'd0);
    word("p5h0", 32'h00000000, 1'b1);
    cfg(32'd5, 32'd9);
    word("p5h9", 32'hFFFFFFFF, 1'b1);
    cfg(32'd100, 32'd50);
    for (int i = 0; i < 6; i++) word("p100h50", w100[i], s100[i]);
    cfg(32'd40, 32'd20);
    word("bad_pre", 32'h000FFFFF, 1'b1);
    bus.cfg_we = 1'b1;
    bus.cfg_period = 32'd0;
    bus.cfg_high = 32'd7;
    word("bad_edge", 32'h0FFFFF00, 1'b1);
    bus.cfg_we = 1'b0;
    chk("bad_err_set", {31'd0, bus.cfg_err}, 32'd1);
    word("bad_post", 32'hFFFF0000, 1'b1);
    chk("bad_err_hold", {31'd0, bus.cfg_err}, 32'd1);
    cfg(32'd8, 32'd3);
    word("good_after_bad", 32'h07070707, 1'b1);
    chk("err_sticky", {31'd0, bus.cfg_err}, 32'd1);
    cfg(32'd40, 32'd20);
    word("tog_a", 32'h000FFFFF, 1'b1);
    word("tog_b", 32'h0FFFFF00, 1'b1);
    bus.en = 1'b0;
    word("tog_last", 32'hFFFF0000, 1'b1);
    chk("tog_last_run", {31'd0, bus.run}, 32'd1);
    word("tog_idle", 32'hFFFFFFFF, 1'b0);
    chk("tog_idle_run", {31'd0, bus.run}, 32'd0);
    chk("tog_idle_wcnt", bus.wcnt, 32'd0);
    bus.en = 1'b1;
    word("tog_lat", 32'hFFFFFFFF, 1'b0);
    word("tog_restart", 32'h000FFFFF, 1'b1);
    chk("tog_restart_wcnt", bus.wcnt, 32'd1);
    rst = 1'b1;
    bus.cfg_we = 1'b1;
    bus.cfg_period = 32'd8;
    bus.cfg_high = 32'd3;
    word("mid_rst", 32'hFFFFFFFF, 1'b0);
    chk("mid_rst_run", {31'd0, bus.run}, 32'd0);
    chk("mid_rst_wcnt", bus.wcnt, 32'd0);
    chk("mid_rst_err", {31'd0, bus.cfg_err}, 32'd0);
    rst = 1'b0;
    bus.cfg_we = 1'b0;
    word("post_rst_lat", 32'hFFFFFFFF, 1'b0);
    word("post_rst_def", 32'h0000FFFF, 1'b1);
    chk("post_rst_wcnt", bus.wcnt, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
